scr1_pipe_fpwb: RTL and testbench

FP write-back stage for the SCR1 pipeline. It sits directly upstream of the FP register file (FPRF) and owns its single write port. It merges results from the multi-cycle FPU, buffered through a small FIFO, with FP load data from the LSU. It also keeps a per-register pending-write scoreboard so the EXU can stall on FP RAW and WAW hazards.

---
 rtl/scr1_pipe_fpwb_pkg.sv | 23 ++
 rtl/scr1_pipe_fpwb_fifo.sv | 54 +++++
 rtl/scr1_pipe_fpwb.sv | 105 ++++++++++
 tb/tb_scr1_pipe_fpwb.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_pipe_fpwb_pkg.sv
// Shared FP write-back types and widths.
// No ports: imported by the FP write-back stage and its FIFO.
package scr1_pipe_fpwb_pkg;

  localparam int unsigned SCR1_MPRF_AWIDTH = 5;
  localparam int unsigned SCR1_XLEN        = 32;
  localparam int unsigned SCR1_FPWB_DEPTH  = 2;

  typedef logic [SCR1_MPRF_AWIDTH-1:0] type_scr1_fprf_addr_v;
  typedef logic [SCR1_XLEN-1:0]        type_scr1_fprf_data_v;

  typedef struct packed {
    type_scr1_fprf_addr_v frd;
    type_scr1_fprf_data_v data;
  } type_scr1_fpwb_req_s;

  function automatic int unsigned fpwb_cnt_w(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/scr1_pipe_fpwb_fifo.sv
// Synchronous FIFO buffering FPU results.
// Ports: clk, rst_n, push/wdata, pop/rdata, empty, full.
module scr1_pipe_fpwb_fifo
  import scr1_pipe_fpwb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = fpwb_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push & ~do_pop)
        cnt <= cnt + 1'b1;
      else if (do_pop & ~do_push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/scr1_pipe_fpwb.sv
// FP write-back: LSU/FPU merge, FPRF write port, hazard scoreboard.
// Ports: EXU issue/decode/hazard/busy, FPU and LSU results, FPRF write.
module scr1_pipe_fpwb
  import scr1_pipe_fpwb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = SCR1_FPWB_DEPTH,
  parameter int unsigned AWIDTH     = SCR1_MPRF_AWIDTH,
  parameter int unsigned DWIDTH     = SCR1_XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exu2fpwb_issue_i,
  input  logic [AWIDTH-1:0] exu2fpwb_issue_frd_i,
  input  logic [AWIDTH-1:0] exu2fpwb_frs1_addr_i,
  input  logic [AWIDTH-1:0] exu2fpwb_frs2_addr_i,
  input  logic [AWIDTH-1:0] exu2fpwb_frs3_addr_i,
  input  logic [AWIDTH-1:0] exu2fpwb_frd_addr_i,
  output logic              fpwb2exu_hazard_o,
  output logic              fpwb2exu_busy_o,
  input  logic              fpu2fpwb_vd_i,
  input  logic [AWIDTH-1:0] fpu2fpwb_frd_i,
  input  logic [DWIDTH-1:0] fpu2fpwb_data_i,
  output logic              fpwb2fpu_rdy_o,
  input  logic              lsu2fpwb_vd_i,
  input  logic [AWIDTH-1:0] lsu2fpwb_frd_i,
  input  logic [DWIDTH-1:0] lsu2fpwb_data_i,
  output logic              fpwb2fprf_w_req_o,
  output logic [AWIDTH-1:0] fpwb2fprf_frd_addr_o,
  output logic [DWIDTH-1:0] fpwb2fprf_frd_data_o
);

  localparam int unsigned NREG = 2 ** AWIDTH;
  localparam int unsigned RW   = AWIDTH + DWIDTH;

  logic            f_push;
  logic            f_pop;
  logic            f_empty;
  logic            f_full;
  logic [RW-1:0]   f_wdata;
  logic [RW-1:0]   f_rdata;
  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_nxt;

  assign f_push  = fpu2fpwb_vd_i & ~f_full;
  assign f_pop   = ~lsu2fpwb_vd_i & ~f_empty;
  assign f_wdata = {fpu2fpwb_frd_i, fpu2fpwb_data_i};

  scr1_pipe_fpwb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW)
  ) i_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (f_push),
    .wdata (f_wdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .empty (f_empty),
    .full  (f_full)
  );

  assign fpwb2fpu_rdy_o = ~f_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpwb2fprf_w_req_o    <= 1'b0;
      fpwb2fprf_frd_addr_o <= '0;
      fpwb2fprf_frd_data_o <= '0;
    end else begin
      fpwb2fprf_w_req_o <= lsu2fpwb_vd_i | ~f_empty;
      if (lsu2fpwb_vd_i) begin
        fpwb2fprf_frd_addr_o <= lsu2fpwb_frd_i;
        fpwb2fprf_frd_data_o <= lsu2fpwb_data_i;
      end else if (~f_empty) begin
        fpwb2fprf_frd_addr_o <= f_rdata[RW-1:DWIDTH];
        fpwb2fprf_frd_data_o <= f_rdata[DWIDTH-1:0];
      end
    end
  end

  // Set is applied after clear so a same-register race keeps the bit.
  always_comb begin
    sb_nxt = sb;
    if (fpwb2fprf_w_req_o)
      sb_nxt[fpwb2fprf_frd_addr_o] = 1'b0;
    if (exu2fpwb_issue_i)
      sb_nxt[exu2fpwb_issue_frd_i] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_nxt;
  end

  assign fpwb2exu_hazard_o = sb[exu2fpwb_frs1_addr_i]
                           | sb[exu2fpwb_frs2_addr_i]
                           | sb[exu2fpwb_frs3_addr_i]
                           | sb[exu2fpwb_frd_addr_i];

  assign fpwb2exu_busy_o = ~f_empty
                         | fpwb2fprf_w_req_o
                         | (|sb);

endmodule

// File: tb/tb_scr1_pipe_fpwb.sv
// Testbench for scr1_pipe_fpwb: scoreboard against a queue model.
// Drives directed scenarios then random traffic.
module tb_scr1_pipe_fpwb;
  import scr1_pipe_fpwb_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue = 1'b0;
  logic [4:0]  issue_frd = '0;
  logic [4:0]  frs1 = '0;
  logic [4:0]  frs2 = '0;
  logic [4:0]  frs3 = '0;
  logic [4:0]  frd_dec = '0;
  logic        fpu_vd = 1'b0;
  logic [4:0]  fpu_frd = '0;
  logic [31:0] fpu_data = '0;
  logic        lsu_vd = 1'b0;
  logic [4:0]  lsu_frd = '0;
  logic [31:0] lsu_data = '0;
  logic        hazard;
  logic        busy;
  logic        rdy;
  logic        w_req;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  always #5 clk = ~clk;

  scr1_pipe_fpwb #(
    .FIFO_DEPTH (DEPTH),
    .AWIDTH     (5),
    .DWIDTH     (32)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .exu2fpwb_issue_i     (issue),
    .exu2fpwb_issue_frd_i (issue_frd),
    .exu2fpwb_frs1_addr_i (frs1),
    .exu2fpwb_frs2_addr_i (frs2),
    .exu2fpwb_frs3_addr_i (frs3),
    .exu2fpwb_frd_addr_i  (frd_dec),
    .fpwb2exu_hazard_o    (hazard),
    .fpwb2exu_busy_o      (busy),
    .fpu2fpwb_vd_i        (fpu_vd),
    .fpu2fpwb_frd_i       (fpu_frd),
    .fpu2fpwb_data_i      (fpu_data),
    .fpwb2fpu_rdy_o       (rdy),
    .lsu2fpwb_vd_i        (lsu_vd),
    .lsu2fpwb_frd_i       (lsu_frd),
    .lsu2fpwb_data_i      (lsu_data),
    .fpwb2fprf_w_req_o    (w_req),
    .fpwb2fprf_frd_addr_o (w_addr),
    .fpwb2fprf_frd_data_o (w_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  type_scr1_fpwb_req_s mq[$];
  type_scr1_fpwb_req_s exp_q[$];
  logic [4:0]          wlog[$];
  bit                  pend [32];
  bit                  ewreq;
  logic [4:0]          ewaddr;
  logic [4:0]          last_addr;
  logic [31:0]         last_data;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic bit pb(input logic [4:0] a);
    return (a == 5'd0) ? 1'b0 : pend[a];
  endfunction

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 1; i < 32; i++) r |= pend[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    ewreq = 1'b0;
    ewaddr = '0;
    last_addr = '0;
    last_data = '0;
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
  endtask

  // Behaviour of one clock edge, from the inputs held this cycle.
  task automatic model_edge();
    type_scr1_fpwb_req_s w;
    bit acc;
    bit nw;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = fpu_vd && (mq.size() < DEPTH);
    nw = 1'b0;
    w = '0;
    if (lsu_vd) begin
      nw = 1'b1;
      w.frd = lsu_frd;
      w.data = lsu_data;
    end else if (mq.size() > 0) begin
      nw = 1'b1;
      w = mq.pop_front();
    end
    if (acc) begin
      type_scr1_fpwb_req_s f;
      f.frd = fpu_frd;
      f.data = fpu_data;
      mq.push_back(f);
    end
    if (ewreq) pend[ewaddr] = 1'b0;
    if (issue && issue_frd != 0) pend[issue_frd] = 1'b1;
    ewreq = nw;
    if (nw) begin
      ewaddr = w.frd;
      last_addr = w.frd;
      last_data = w.data;
      exp_q.push_back(w);
    end
  endtask

  always @(negedge clk) begin
    chk("w_req", w_req, ewreq);
    chk("addr_hold", w_addr, last_addr);
    chk("data_hold", w_data, last_data);
    chk("rdy", rdy, mq.size() < DEPTH);
    chk("hazard", hazard,
        pb(frs1) | pb(frs2) | pb(frs3) | pb(frd_dec));
    chk("busy", busy,
        (mq.size() > 0) | ewreq | any_pend());
    if (w_req) begin
      wlog.push_back(w_addr);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 1'b1, 1'b0);
      end else begin
        type_scr1_fpwb_req_s e;
        e = exp_q.pop_front();
        chk("wr_addr", w_addr, e.frd);
        chk("wr_data", w_data, e.data);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_in();
    issue = 0;
    fpu_vd = 0;
    lsu_vd = 0;
  endtask

  task automatic fpu_send(input logic [4:0] a,
                          input logic [31:0] d);
    bit done = 1'b0;
    fpu_vd = 1;
    fpu_frd = a;
    fpu_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      done = (mq.size() < DEPTH);
      cyc();
    end
    fpu_vd = 0;
    if (!done) chk("fpu_accept_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wreq", w_req, 1'b0);
    chk("rst_addr", w_addr, 5'd0);
    repeat (10) cyc();

    // LSU single write
    lsu_vd = 1; lsu_frd = 5; lsu_data = 32'h3F800000;
    cyc();
    lsu_vd = 0;
    #3 chk("lsu_wreq", w_req, 1'b1);
    chk("lsu_addr", w_addr, 5'd5);
    chk("lsu_data", w_data, 32'h3F800000);
    cyc();
    chk("lsu_once", w_req, 1'b0);
    repeat (2) cyc();

    // Scoreboard RAW on f7
    issue = 1; issue_frd = 7; frs2 = 7;
    cyc();
    issue = 0;
    chk("sb_haz_set", hazard, 1'b1);
    cyc();
    fpu_send(7, 32'h40000000);
    chk("sb_haz_wait", hazard, 1'b1);
    repeat (3) cyc();
    chk("sb_haz_clr", hazard, 1'b0);
    frs2 = 0;

    // LSU / FPU collision
    wlog.delete();
    lsu_vd = 1; lsu_frd = 9; lsu_data = 32'h99;
    fpu_vd = 1; fpu_frd = 3; fpu_data = 32'h33;
    cyc();
    fpu_frd = 4; fpu_data = 32'h44;
    cyc();
    fpu_vd = 0;
    chk("coll_rdy0", rdy, 1'b0);
    cyc();
    lsu_vd = 0;
    repeat (4) cyc();
    chk("coll_cnt", wlog.size(), 5);
    if (wlog.size() == 5) begin
      logic [4:0] ord [5];
      ord = '{5'd9, 5'd9, 5'd9, 5'd3, 5'd4};
      for (int i = 0; i < 5; i++)
        chk("coll_order", wlog[i], ord[i]);
    end

    // Set/clear race on f2
    lsu_vd = 1; lsu_frd = 2; lsu_data = 32'h22;
    cyc();
    lsu_vd = 0;
    issue = 1; issue_frd = 2; frs1 = 2;
    cyc();
    issue = 0;
    cyc();
    chk("race_keep", hazard, 1'b1);
    lsu_vd = 1;
    cyc();
    lsu_vd = 0;
    repeat (2) cyc();
    chk("race_clr", hazard, 1'b0);
    frs1 = 0;

    // Address 0
    wlog.delete();
    issue = 1; issue_frd = 0; frd_dec = 0;
    cyc();
    issue = 0;
    chk("a0_haz", hazard, 1'b0);
    fpu_send(0, 32'hABCD);
    repeat (3) cyc();
    chk("a0_wcnt", wlog.size(), 1);
    if (wlog.size() == 1) chk("a0_addr", wlog[0], 5'd0);

    // Reset with two FIFO entries held
    wlog.delete();
    lsu_vd = 1; lsu_frd = 1; lsu_data = 32'h11;
    issue = 1; issue_frd = 12; frs3 = 12;
    fpu_vd = 1; fpu_frd = 10; fpu_data = 32'hA;
    cyc();
    issue = 0;
    fpu_frd = 11; fpu_data = 32'hB;
    cyc();
    fpu_vd = 0;
    chk("pre_rst_full", rdy, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    idle_in();
    #1;
    chk("arst_wreq", w_req, 1'b0);
    chk("arst_rdy", rdy, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_haz", hazard, 1'b0);
    repeat (2) cyc();
    #2 rst_n = 1'b1;
    wlog.delete();
    repeat (6) cyc();
    chk("post_rst_wr", wlog.size(), 0);
    frs3 = 0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      lsu_vd    = ($urandom_range(0, 9) < 3);
      lsu_frd   = 5'($urandom_range(0, 7));
      lsu_data  = $urandom;
      fpu_vd    = ($urandom_range(0, 1) == 1);
      fpu_frd   = 5'($urandom_range(0, 7));
      fpu_data  = $urandom;
      issue     = ($urandom_range(0, 9) < 3);
      issue_frd = 5'($urandom_range(0, 7));
      frs1      = 5'($urandom_range(0, 7));
      frs2      = 5'($urandom_range(0, 7));
      frs3      = 5'($urandom_range(0, 7));
      frd_dec   = 5'($urandom_range(0, 7));
      cyc();
    end
    idle_in();
    repeat (10) cyc();
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_fifo", mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
